// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one synchronous memory port between an instruction-fetch requester
//   and a load/store requester. A grant is decided in IDLE and the granted
//   request is driven onto mem_* in that same cycle. Memory returns read data
//   one cycle later (the RESP state), which is registered, so the requester
//   sees a one-cycle valid pulse two cycles after its grant.
//
//   Data requests win by default. A fetch that has lost STARVE_MAX
//   consecutive decisions while still requesting wins the next one.
//
//   Requesters hold their request until they observe their valid pulse. The
//   valid outputs are registered, so a requester can drop its request, or
//   present its next request, in the same cycle that it sees valid high.
//   That cycle is an IDLE cycle and may already carry the next grant.
//
// Ports
//   clk, rst_n                     clock, synchronous active-low reset
//   if_req, if_addr                fetch request and address
//   if_rdata, if_valid             fetched word and completion pulse
//   d_req, d_we, d_addr,
//   d_wdata, d_funct3              load/store request
//   d_rdata, d_valid               load result and completion pulse
//   mem_addr, mem_we, mem_wdata,
//   mem_funct3                     shared memory port (combinational, grant cycle only)
//   mem_rdata                      memory read data, one cycle after the address
//   busy                           high whenever the arbiter is not in IDLE
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [2:0]        d_funct3,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_valid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [2:0]        mem_funct3,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_LIMIT = CNT_W'(STARVE_MAX);

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_IF_RESP = 2'b01,
    S_D_RESP  = 2'b10
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CNT_W-1:0]  r_starve_cnt;
  logic [CNT_W-1:0]  w_starve_nxt;
  logic              w_starved;
  logic              w_grant_if;
  logic              w_grant_d;
  logic              r_d_we;
  logic              r_if_valid;
  logic              r_d_valid;
  logic [DATA_W-1:0] r_if_rdata;
  logic [DATA_W-1:0] r_d_rdata;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Grant decision, next state, starvation counter update and memory port drive.
  always_comb begin
    w_state_nxt  = r_state;
    w_grant_if   = 1'b0;
    w_grant_d    = 1'b0;
    w_starve_nxt = r_starve_cnt;
    w_starved    = (r_starve_cnt == STARVE_LIMIT);
    mem_addr     = {ADDR_W{1'b0}};
    mem_we       = 1'b0;
    mem_wdata    = {DATA_W{1'b0}};
    mem_funct3   = 3'b000;

    case (r_state)
      S_IDLE: begin
        // Grants are suppressed while reset is held, which also keeps mem_we low.
        if (rst_n && if_req && (w_starved || !d_req)) begin
          w_grant_if  = 1'b1;
          w_state_nxt = S_IF_RESP;
        end else if (rst_n && d_req) begin
          w_grant_d   = 1'b1;
          w_state_nxt = S_D_RESP;
        end else begin
          w_state_nxt = S_IDLE;
        end

        if (!if_req || w_grant_if) begin
          w_starve_nxt = {CNT_W{1'b0}};
        end else if (w_grant_d && !w_starved) begin
          w_starve_nxt = r_starve_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
          w_starve_nxt = r_starve_cnt;
        end
      end
      S_IF_RESP: begin
        w_state_nxt = S_IDLE;
      end
      S_D_RESP: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    if (w_grant_if) begin
      mem_addr   = if_addr;
      mem_funct3 = 3'b010;
    end else if (w_grant_d) begin
      mem_addr   = d_addr;
      mem_we     = d_we;
      mem_wdata  = d_wdata;
      mem_funct3 = d_funct3;
    end else begin
      mem_addr   = {ADDR_W{1'b0}};
    end
  end

  // Response capture, valid pulses and starvation counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_starve_cnt <= {CNT_W{1'b0}};
      r_d_we       <= 1'b0;
      r_if_valid   <= 1'b0;
      r_d_valid    <= 1'b0;
      r_if_rdata   <= {DATA_W{1'b0}};
      r_d_rdata    <= {DATA_W{1'b0}};
    end else begin
      r_starve_cnt <= w_starve_nxt;
      r_if_valid   <= (r_state == S_IF_RESP);
      r_d_valid    <= (r_state == S_D_RESP);
      // Remember the direction of the granted access; d_we need not stay stable.
      if (w_grant_d) begin
        r_d_we <= d_we;
      end
      if (r_state == S_IF_RESP) begin
        r_if_rdata <= mem_rdata;
      end
      // Stores leave the last load result in place.
      if ((r_state == S_D_RESP) && !r_d_we) begin
        r_d_rdata <= mem_rdata;
      end
    end
  end

  assign if_valid = r_if_valid;
  assign d_valid  = r_d_valid;
  assign if_rdata = r_if_rdata;
  assign d_rdata  = r_d_rdata;
  assign busy     = (r_state != S_IDLE);

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, the address width.
REQ-002 SHALL have parameter DATA_W, default 32, the data width.
REQ-003 SHALL have parameter STARVE_MAX, default 4, the number of consecutive fetch losses that forces a fetch grant.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-006 SHALL have port if_req, input, 1 bit: instruction-fetch read request, held high until if_valid.
REQ-007 SHALL have port if_addr, input, ADDR_W bits: fetch address, stable while if_req is high.
REQ-008 SHALL have port if_rdata, output, DATA_W bits: fetched word.
REQ-009 SHALL have port if_valid, output, 1 bit: one-cycle fetch completion pulse.
REQ-010 SHALL have port d_req, input, 1 bit: load/store request, held high until d_valid.
REQ-011 SHALL have port d_we, input, 1 bit: 1 = store, 0 = load.
REQ-012 SHALL have port d_addr, input, ADDR_W bits: data address.
REQ-013 SHALL have port d_wdata, input, DATA_W bits: store data.
REQ-014 SHALL have port d_funct3, input, 3 bits: access size/sign code, passed to memory.
REQ-015 SHALL have port d_rdata, output, DATA_W bits: load result.
REQ-016 SHALL have port d_valid, output, 1 bit: one-cycle load/store completion pulse.
REQ-017 SHALL have ports mem_addr (ADDR_W), mem_we (1), mem_wdata (DATA_W) and mem_funct3 (3), all outputs driving the shared memory port.
REQ-018 SHALL have port mem_rdata, input, DATA_W bits: memory read data, valid one cycle after the address is presented.
REQ-019 SHALL have port busy, output, 1 bit: high whenever the FSM is not in IDLE.

Function
REQ-020 SHALL implement the FSM states IDLE, IF_RESP, D_RESP.
REQ-021 In IDLE with any request, SHALL make a grant decision, drive the granted requester's address/controls onto mem_* in that same cycle, and move to IF_RESP (fetch grant) or D_RESP (data grant).
REQ-022 Grant priority SHALL be: data over fetch, except when starve_cnt == STARVE_MAX and if_req is high, in which case fetch wins.
REQ-023 starve_cnt (clog2(STARVE_MAX+1) bits) SHALL increment when if_req is high and data is granted, saturate at STARVE_MAX, and clear on a fetch grant or whenever if_req is low in IDLE.
REQ-024 On a fetch grant: mem_addr=if_addr, mem_we=0, mem_funct3=3'b010 (word).
REQ-025 On a data grant: mem_addr=d_addr, mem_we=d_we, mem_wdata=d_wdata, mem_funct3=d_funct3; mem_we SHALL be high for exactly the grant cycle.
REQ-026 With no grant (IDLE without requests, or any RESP state): mem_we=0, mem_addr=0, mem_wdata=0, mem_funct3=0.
REQ-027 In IF_RESP, SHALL register mem_rdata into if_rdata, pulse if_valid on the following cycle, and return to IDLE.
REQ-028 In D_RESP, SHALL register mem_rdata into d_rdata for a load only (a store leaves d_rdata unchanged), pulse d_valid on the following cycle, and return to IDLE.
REQ-029 No new grant SHALL be issued in a RESP state; latency from grant to valid SHALL be 2 cycles, with a minimum of 2 cycles between grants.
REQ-030 if_rdata and d_rdata SHALL hold their values until the next respective load or fetch response.
REQ-031 On simultaneous if_req and d_req, the loser SHALL keep its request pending and SHALL be considered in the next IDLE cycle, with no lost or duplicated transaction.

Reset
REQ-032 While rst_n is low at a clock edge, the block SHALL reset to: state=IDLE, starve_cnt=0, if_valid=0, d_valid=0, if_rdata=0, d_rdata=0.
REQ-033 mem_we SHALL be forced to 0 combinationally while rst_n is low.
REQ-034 Reset asserted mid-transaction SHALL abort the transaction with no valid pulse for it.

Verification
REQ-035 Fetch only: if_req=1, if_addr=0x10, mem_rdata=0x00500093 -> mem_addr=0x10 at grant; if_valid pulse 2 cycles later; if_rdata=0x00500093.
REQ-036 Store: d_req=1, d_we=1, d_addr=0x2000, d_wdata=0xDEADBEEF, d_funct3=2 -> mem_we high exactly 1 cycle with those values; d_valid 2 cycles later; d_rdata unchanged.
REQ-037 Contention: if_req and d_req both high -> data granted first, fetch granted in the next IDLE cycle; both valids pulse exactly once.
REQ-038 Starvation: if_req held with continuous back-to-back d_req -> after 4 data grants, fetch granted, then starve_cnt=0.
REQ-039 Reset in D_RESP of a load -> no d_valid pulse; all outputs at reset values; a fetch issued after reset completes normally.
